hopfield_engine: RTL and testbench



---
 rtl/hopfield_if.sv | 31 +++
 rtl/hopfield_engine.sv | 143 ++++++++++++++
 tb/tb_hopfield_engine.sv | 268 ++++++++++++++++++++++++++
 3 files changed

// File: rtl/hopfield_if.sv
// Bus between the weight/pattern loader (master) and the Hopfield recall engine (slave).
// start is sampled only while busy=0; done pulses for one cycle once results are final, and converged/sweeps/state_out then hold until the next start or rst.
interface hopfield_if #(
  parameter int N  = 25,
  parameter int WW = 8
);
  localparam int AW = $clog2(N * N);

  logic          wr_en;
  logic [AW-1:0] wr_addr;
  logic [WW-1:0] wr_data;
  logic          pat_load;
  logic [N-1:0]  pat_in;
  logic          start;
  logic          busy;
  logic          done;
  logic          converged;
  logic [7:0]    sweeps;
  logic [N-1:0]  state_out;
  logic [2:0]    dbg_state;

  modport master (
    output wr_en, wr_addr, wr_data, pat_load, pat_in, start,
    input  busy, done, converged, sweeps, state_out, dbg_state
  );

  modport slave (
    input  wr_en, wr_addr, wr_data, pat_load, pat_in, start,
    output busy, done, converged, sweeps, state_out, dbg_state
  );
endinterface

// File: rtl/hopfield_engine.sv
// Sequential Hopfield recall: one weighted term per cycle, in-order asynchronous neuron
// updates, sweeps repeated until a change-free sweep or the sweep limit.
module hopfield_engine #(
  parameter int N          = 25,
  parameter int WW         = 8,
  parameter int MAX_SWEEPS = 16,
  parameter int AW         = $clog2(N * N),
  parameter int SW         = WW + $clog2(N) + 1
) (
  input  logic     clk,
  input  logic     rst,
  hopfield_if.slave bus
);
  localparam int IW = $clog2(N);
  localparam int NN = N * N;

  typedef enum logic [2:0] {IDLE, ACC, UPD, CHECK, DONE} state_e;

  state_e               st_q, st_d;
  logic [IW-1:0]        i_q, i_d, j_q, j_d;
  logic signed [SW-1:0] sum_q, sum_d;
  logic                 changed_q, changed_d;
  logic                 busy_q, busy_d;
  logic                 done_q, done_d;
  logic                 conv_q, conv_d;
  logic [7:0]           sweeps_q, sweeps_d;
  logic [N-1:0]         s_q, s_d;

  logic [WW-1:0]        mem_q [NN];
  logic [AW-1:0]        rd_addr;
  logic [WW-1:0]        w_raw;
  logic signed [SW-1:0] w_ext, term;
  logic                 new_bit;
  logic                 wr_ok;

  // Weight of neuron j into neuron i lives at i*N+j.
  assign rd_addr = AW'(i_q) * AW'(N) + AW'(j_q);
  assign w_raw   = mem_q[rd_addr];
  assign w_ext   = {{(SW - WW){w_raw[WW-1]}}, w_raw};
  assign term    = s_q[j_q] ? w_ext : -w_ext;
  // A zero sum keeps the neuron's current value.
  assign new_bit = (sum_q == '0) ? s_q[i_q] : ~sum_q[SW-1];

  assign wr_ok = !rst && (st_q == IDLE) && bus.wr_en && (32'(bus.wr_addr) < NN);

  always_ff @(posedge clk) begin
    if (wr_ok) mem_q[bus.wr_addr] <= bus.wr_data;
  end

  always_comb begin
    st_d      = st_q;
    i_d       = i_q;
    j_d       = j_q;
    sum_d     = sum_q;
    changed_d = changed_q;
    busy_d    = busy_q;
    done_d    = 1'b0;
    conv_d    = conv_q;
    sweeps_d  = sweeps_q;
    s_d       = s_q;
    case (st_q)
      IDLE: begin
        if (bus.pat_load) begin
          s_d = bus.pat_in;
        end else if (bus.start) begin
          i_d       = '0;
          j_d       = '0;
          sum_d     = '0;
          changed_d = 1'b0;
          sweeps_d  = '0;
          conv_d    = 1'b0;
          busy_d    = 1'b1;
          st_d      = ACC;
        end
      end
      ACC: begin
        sum_d = sum_q + term;
        if (j_q == IW'(N - 1)) st_d = UPD;
        else                   j_d  = j_q + IW'(1);
      end
      UPD: begin
        s_d[i_q]  = new_bit;
        changed_d = changed_q | (new_bit != s_q[i_q]);
        sum_d     = '0;
        j_d       = '0;
        if (i_q == IW'(N - 1)) begin
          st_d = CHECK;
        end else begin
          i_d  = i_q + IW'(1);
          st_d = ACC;
        end
      end
      CHECK: begin
        sweeps_d = sweeps_q + 8'd1;
        if (!changed_q || (sweeps_d == 8'(MAX_SWEEPS))) begin
          conv_d = !changed_q;
          busy_d = 1'b0;
          done_d = 1'b1;
          st_d   = DONE;
        end else begin
          changed_d = 1'b0;
          i_d       = '0;
          st_d      = ACC;
        end
      end
      DONE: st_d = IDLE;
      default: st_d = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      st_q      <= IDLE;
      i_q       <= '0;
      j_q       <= '0;
      sum_q     <= '0;
      changed_q <= 1'b0;
      busy_q    <= 1'b0;
      done_q    <= 1'b0;
      conv_q    <= 1'b0;
      sweeps_q  <= '0;
      s_q       <= '0;
    end else begin
      st_q      <= st_d;
      i_q       <= i_d;
      j_q       <= j_d;
      sum_q     <= sum_d;
      changed_q <= changed_d;
      busy_q    <= busy_d;
      done_q    <= done_d;
      conv_q    <= conv_d;
      sweeps_q  <= sweeps_d;
      s_q       <= s_d;
    end
  end

  assign bus.busy      = busy_q;
  assign bus.done      = done_q;
  assign bus.converged = conv_q;
  assign bus.sweeps    = sweeps_q;
  assign bus.state_out = s_q;
  assign bus.dbg_state = st_q;
endmodule

// File: tb/tb_hopfield_engine.sv
// Bench for hopfield_engine: three instances (N=25, N=4, N=2 with a 4-sweep limit),
// randomized weights/patterns checked against a sweep-level reference model.
module tb_hopfield_engine;
  typedef struct packed {
    logic        busy;
    logic        done;
    logic        conv;
    logic [7:0]  sweeps;
    logic [63:0] state;
  } obs_t;

  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  hopfield_if #(.N(25), .WW(8)) if25 ();
  hopfield_if #(.N(4),  .WW(8)) if4 ();
  hopfield_if #(.N(2),  .WW(8)) if2 ();

  hopfield_engine #(.N(25), .WW(8), .MAX_SWEEPS(16)) u25 (.clk(clk), .rst(rst), .bus(if25));
  hopfield_engine #(.N(4),  .WW(8), .MAX_SWEEPS(16)) u4  (.clk(clk), .rst(rst), .bus(if4));
  hopfield_engine #(.N(2),  .WW(8), .MAX_SWEEPS(4))  u2  (.clk(clk), .rst(rst), .bus(if2));

  int          n_checks = 0;
  int          n_pass   = 0;
  int          mw [3][4096];
  logic [63:0] exp_q [$];

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic set_in(input int id, input logic we, input int addr, input int data,
                        input logic pl, input logic [63:0] pin, input logic st);
    case (id)
      0: begin
        if25.wr_en = we; if25.wr_addr = 10'(addr); if25.wr_data = 8'(data);
        if25.pat_load = pl; if25.pat_in = pin[24:0]; if25.start = st;
      end
      1: begin
        if4.wr_en = we; if4.wr_addr = 4'(addr); if4.wr_data = 8'(data);
        if4.pat_load = pl; if4.pat_in = pin[3:0]; if4.start = st;
      end
      default: begin
        if2.wr_en = we; if2.wr_addr = 2'(addr); if2.wr_data = 8'(data);
        if2.pat_load = pl; if2.pat_in = pin[1:0]; if2.start = st;
      end
    endcase
  endtask

  function automatic obs_t get_obs(input int id);
    obs_t o;
    o = '0;
    case (id)
      0: begin
        o.busy = if25.busy; o.done = if25.done; o.conv = if25.converged;
        o.sweeps = if25.sweeps; o.state = 64'(if25.state_out);
      end
      1: begin
        o.busy = if4.busy; o.done = if4.done; o.conv = if4.converged;
        o.sweeps = if4.sweeps; o.state = 64'(if4.state_out);
      end
      default: begin
        o.busy = if2.busy; o.done = if2.done; o.conv = if2.converged;
        o.sweeps = if2.sweeps; o.state = 64'(if2.state_out);
      end
    endcase
    return o;
  endfunction

  task automatic wr_weight(input int id, input int addr, input int val);
    set_in(id, 1'b1, addr, val, 1'b0, 64'd0, 1'b0);
    mw[id][addr] = val;
    tick();
    set_in(id, 1'b0, 0, 0, 1'b0, 64'd0, 1'b0);
  endtask

  task automatic load_pat(input int id, input logic [63:0] pat);
    set_in(id, 1'b0, 0, 0, 1'b1, pat, 1'b0);
    tick();
    set_in(id, 1'b0, 0, 0, 1'b0, 64'd0, 1'b0);
  endtask

  // Pulses start, then waits (bounded) for done; cyc = edges from the start edge to done, -1 on timeout.
  task automatic run_dut(input int id, input bit disturb, output obs_t at_done,
                         output obs_t after, output logic busy0, output int cyc);
    set_in(id, 1'b0, 0, 0, 1'b0, 64'd0, 1'b1);
    tick();
    set_in(id, 1'b0, 0, 0, 1'b0, 64'd0, 1'b0);
    busy0   = get_obs(id).busy;
    cyc     = 0;
    at_done = '0;
    while (cyc < 20000) begin
      if (disturb && (cyc % 20 == 5))
        set_in(id, 1'b1, 0, int'($urandom_range(0, 255)), 1'b1, {$urandom, $urandom}, 1'b1);
      else
        set_in(id, 1'b0, 0, 0, 1'b0, 64'd0, 1'b0);
      tick();
      cyc++;
      at_done = get_obs(id);
      if (at_done.done) break;
    end
    set_in(id, 1'b0, 0, 0, 1'b0, 64'd0, 1'b0);
    if (!at_done.done) cyc = -1;
    tick();
    after = get_obs(id);
  endtask

  // Reference recall: whole sweeps over signed integer sums, pushing the final state.
  task automatic model_run(input int id, input int n, input int max_sw, input logic [63:0] pat,
                           output int sw, output bit conv);
    logic [63:0] s;
    int          sum;
    bit          chg;
    logic        nb;
    s    = pat & ((64'd1 << n) - 64'd1);
    sw   = 0;
    conv = 1'b0;
    while (1) begin
      chg = 1'b0;
      for (int i = 0; i < n; i++) begin
        sum = 0;
        for (int j = 0; j < n; j++) sum += s[j] ? mw[id][i*n+j] : -mw[id][i*n+j];
        nb = (sum > 0) ? 1'b1 : (sum < 0) ? 1'b0 : s[i];
        if (nb != s[i]) chg = 1'b1;
        s[i] = nb;
      end
      sw++;
      if (!chg) begin conv = 1'b1; break; end
      if (sw == max_sw) break;
    end
    exp_q.push_back(s);
  endtask

  task automatic test_reset();
    obs_t o;
    rst = 1'b1;
    for (int c = 0; c < 2; c++) begin
      for (int id = 0; id < 3; id++)
        set_in(id, 1'b0, 0, 0, 1'($urandom_range(0, 1)), {$urandom, $urandom}, 1'($urandom_range(0, 1)));
      tick();
    end
    for (int id = 0; id < 3; id++) set_in(id, 1'b0, 0, 0, 1'b0, 64'd0, 1'b0);
    rst = 1'b0;
    for (int id = 0; id < 3; id++) begin
      o = get_obs(id);
      n_checks++; if (o !== '0) $display("FAIL reset_outputs[%0d]: got %h want 0", id, o); else n_pass++;
    end
  endtask

  task automatic test_hebbian4();
    obs_t o, a; logic b0; int cyc, sw; bit cv; logic [63:0] e;
    load_pat(1, 64'b1011);
    model_run(1, 4, 16, 64'b1011, sw, cv);
    run_dut(1, 1'b0, o, a, b0, cyc);
    e = exp_q.pop_front();
    n_checks++; if (o.state !== 64'b1010) $display("FAIL heb_state: got %h want 1010", o.state); else n_pass++;
    n_checks++; if (o.state !== e) $display("FAIL heb_model: got %h want %h", o.state, e); else n_pass++;
    n_checks++; if (o.conv !== 1'b1) $display("FAIL heb_conv: got %b want 1", o.conv); else n_pass++;
    n_checks++; if (o.sweeps !== 8'd2) $display("FAIL heb_sweeps: got %0d want 2", o.sweeps); else n_pass++;
    n_checks++; if (cyc !== 42) $display("FAIL heb_latency: got %0d want 42", cyc); else n_pass++;
    n_checks++; if (b0 !== 1'b1) $display("FAIL heb_busy: got %b want 1", b0); else n_pass++;
    n_checks++; if ({a.done, a.busy} !== 2'b00) $display("FAIL heb_done_pulse: got %b want 00", {a.done, a.busy}); else n_pass++;
  endtask

  task automatic test_zero25();
    obs_t o, a; logic b0; int cyc;
    for (int k = 0; k < 625; k++) wr_weight(0, k, 0);
    load_pat(0, 64'h1ABCDEF);
    run_dut(0, 1'b0, o, a, b0, cyc);
    n_checks++; if (cyc !== 651) $display("FAIL zero_latency: got %0d want 651", cyc); else n_pass++;
    n_checks++; if (o.state !== 64'h1ABCDEF) $display("FAIL zero_state: got %h want 1abcdef", o.state); else n_pass++;
    n_checks++; if ({o.conv, o.sweeps} !== {1'b1, 8'd1}) $display("FAIL zero_conv_sweeps: got %b/%0d want 1/1", o.conv, o.sweeps); else n_pass++;
  endtask

  task automatic test_oscillate2();
    obs_t o, a; logic b0; int cyc;
    wr_weight(2, 0, 0);
    wr_weight(2, 1, 1);
    wr_weight(2, 2, -1);
    wr_weight(2, 3, 0);
    load_pat(2, 64'b00);
    run_dut(2, 1'b0, o, a, b0, cyc);
    n_checks++; if (cyc !== 28) $display("FAIL osc_latency: got %0d want 28", cyc); else n_pass++;
    n_checks++; if (o.state !== 64'b01) $display("FAIL osc_state: got %h want 01", o.state); else n_pass++;
    n_checks++; if ({o.conv, o.sweeps} !== {1'b0, 8'd4}) $display("FAIL osc_conv_sweeps: got %b/%0d want 0/4", o.conv, o.sweeps); else n_pass++;
    n_checks++; if ({a.conv, a.sweeps, a.state} !== {o.conv, 8'd4, 64'b01}) $display("FAIL osc_hold: got %b/%0d/%h want 0/4/01", a.conv, a.sweeps, a.state); else n_pass++;
  endtask

  task automatic test_load_start();
    obs_t o; logic [63:0] p;
    p = 64'($urandom_range(0, 15));
    set_in(1, 1'b0, 0, 0, 1'b1, p, 1'b1);
    tick();
    set_in(1, 1'b0, 0, 0, 1'b0, 64'd0, 1'b0);
    o = get_obs(1);
    n_checks++; if ({o.busy, o.state} !== {1'b0, p}) $display("FAIL load_start: got %b/%h want 0/%h", o.busy, o.state, p); else n_pass++;
  endtask

  task automatic test_random(input int id, input int n, input int max_sw, input int trials,
                             input int wlo, input int whi, input bit disturb);
    obs_t o, a; logic b0; int cyc, sw; bit cv; logic [63:0] p, e;
    for (int t = 0; t < trials; t++) begin
      for (int k = 0; k < n * n; k++) wr_weight(id, k, int'($urandom_range(0, whi - wlo)) + wlo);
      p = {$urandom, $urandom} & ((64'd1 << n) - 64'd1);
      load_pat(id, p);
      model_run(id, n, max_sw, p, sw, cv);
      run_dut(id, disturb, o, a, b0, cyc);
      e = exp_q.pop_front();
      n_checks++; if (o.state !== e) $display("FAIL rnd%0d_state: got %h want %h", id, o.state, e); else n_pass++;
      n_checks++; if ({o.conv, o.sweeps} !== {cv, 8'(sw)}) $display("FAIL rnd%0d_conv_sweeps: got %b/%0d want %b/%0d", id, o.conv, o.sweeps, cv, sw); else n_pass++;
      n_checks++; if (cyc !== sw * (n * (n + 1) + 1)) $display("FAIL rnd%0d_latency: got %0d want %0d", id, cyc, sw * (n * (n + 1) + 1)); else n_pass++;
    end
  endtask

  task automatic test_reset_mid();
    obs_t o, a; logic b0; int cyc, sw, ndone; bit cv; logic [63:0] p, e;
    p = 64'($urandom) & 64'h1FFFFFF;
    load_pat(0, p);
    set_in(0, 1'b0, 0, 0, 1'b0, 64'd0, 1'b1);
    tick();
    set_in(0, 1'b0, 0, 0, 1'b0, 64'd0, 1'b0);
    for (int c = 1; c < 100; c++) tick();
    rst = 1'b1;
    tick();
    rst = 1'b0;
    o = get_obs(0);
    n_checks++; if (o !== '0) $display("FAIL mid_reset: got %h want 0", o); else n_pass++;
    ndone = 0;
    for (int c = 0; c < 800; c++) begin
      tick();
      if (get_obs(0).done) ndone++;
    end
    n_checks++; if (ndone !== 0) $display("FAIL mid_no_done: got %0d pulses want 0", ndone); else n_pass++;
    load_pat(0, p);
    model_run(0, 25, 16, p, sw, cv);
    run_dut(0, 1'b0, o, a, b0, cyc);
    e = exp_q.pop_front();
    n_checks++; if (o.state !== e) $display("FAIL mid_rerun_state: got %h want %h", o.state, e); else n_pass++;
    n_checks++; if ({o.conv, o.sweeps} !== {cv, 8'(sw)}) $display("FAIL mid_rerun_conv: got %b/%0d want %b/%0d", o.conv, o.sweeps, cv, sw); else n_pass++;
    n_checks++; if (cyc !== sw * 651) $display("FAIL mid_rerun_latency: got %0d want %0d", cyc, sw * 651); else n_pass++;
  endtask

  initial begin
    for (int id = 0; id < 3; id++) set_in(id, 1'b0, 0, 0, 1'b0, 64'd0, 1'b0);
    rst = 1'b1;
    tick();
    tick();
    rst = 1'b0;
    // Hebbian weights for 4'b1010 go in before the reset test so they must survive it.
    for (int i = 0; i < 4; i++)
      for (int j = 0; j < 4; j++)
        wr_weight(1, i * 4 + j, (i == j) ? 0 : ((i % 2 == 1) == (j % 2 == 1)) ? 1 : -1);
    test_reset();
    test_hebbian4();
    test_zero25();
    test_oscillate2();
    test_load_start();
    test_random(1, 4, 16, 6, -128, 127, 1'b0);
    test_random(2, 2, 4, 4, -128, 127, 1'b0);
    test_random(0, 25, 16, 1, -8, 8, 1'b0);
    test_random(1, 4, 16, 3, -128, 127, 1'b1);
    test_reset_mid();
    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end
endmodule
